// File: rtl/sample_accum_ctrl.sv
// Run sequencer for the 1000-sample counter: clears counter and accumulator on start,
// adds each accepted sample, and publishes the run total with a one-cycle done pulse.
module sample_accum_ctrl #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 26
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] sample,
  input  logic              one_k_samples,
  output logic              cnt_up,
  output logic              clear,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ACC_W-1:0]  sum
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    ADD,
    CHECK,
    DONE
  } state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [DATA_W-1:0]   hold_q;
  logic [ACC_W-1:0]    sum_q;
  logic                cnt_up_q;
  logic                clear_q;
  logic                busy_q;
  logic                done_q;
  logic                overrun_q;

  assign acc_d = acc_q + ACC_W'(hold_q);

  // Control outputs are registered alongside the state, so each one is set on the
  // transition into the state it belongs to and therefore decodes cleanly from it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      hold_q    <= '0;
      sum_q     <= '0;
      cnt_up_q  <= 1'b0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_up_q <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CLEAR;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          acc_q     <= '0;
          overrun_q <= data_ready;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (data_ready) begin
            hold_q   <= sample;
            cnt_up_q <= 1'b1;
            state_q  <= ADD;
          end
        end
        ADD: begin
          acc_q   <= acc_d;
          state_q <= CHECK;
          if (data_ready) begin
            overrun_q <= 1'b1;
          end
        end
        CHECK: begin
          if (data_ready) begin
            overrun_q <= 1'b1;
          end
          // The counter flag settles one cycle after cnt_up, which is exactly this state.
          if (one_k_samples) begin
            sum_q   <= acc_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cnt_up  = cnt_up_q;
  assign clear   = clear_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;
  assign sum     = sum_q;

endmodule

// File: tb/tb_sample_accum_ctrl.sv
// Directed bench for sample_accum_ctrl with a behavioural model of the 1000-sample counter.
module tb_sample_accum_ctrl;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 26;

  logic              clk;
  logic              n_rst;
  logic              start;
  logic              data_ready;
  logic [DATA_W-1:0] sample;
  logic              one_k_samples;
  logic              cnt_up;
  logic              clear;
  logic              busy;
  logic              done;
  logic              overrun;
  logic [ACC_W-1:0]  sum;

  int checks = 0;
  int errors = 0;
  int clearCount = 0;
  int cntUpCount = 0;
  int doneCount = 0;
  int cntModel;
  logic [ACC_W-1:0] lastSum;

  typedef struct {
    logic [DATA_W-1:0] value;
    bit                ramp;
    int                gap;
    logic [ACC_W-1:0]  expSum;
  } runVec_t;

  runVec_t vecs[4];

  sample_accum_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .data_ready   (data_ready),
    .sample       (sample),
    .one_k_samples(one_k_samples),
    .cnt_up       (cnt_up),
    .clear        (clear),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .sum          (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter block model: flag rises the cycle after the 1000th cnt_up pulse.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cntModel      <= 0;
      one_k_samples <= 1'b0;
    end else if (clear) begin
      cntModel      <= 0;
      one_k_samples <= 1'b0;
    end else if (cnt_up) begin
      if (cntModel == 999) begin
        cntModel      <= 0;
        one_k_samples <= 1'b1;
      end else begin
        cntModel      <= cntModel + 1;
        one_k_samples <= 1'b0;
      end
    end else begin
      one_k_samples <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      if (clear) clearCount++;
      if (cnt_up) cntUpCount++;
      if (done) doneCount++;
      if (cnt_up || clear) begin
        checks++;
        if (cnt_up && clear) begin
          errors++;
          $display("[TB] FAIL cntUpClearExclusive: actual cnt_up=%0b clear=%0b required not both", cnt_up, clear);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic resetCounts();
    clearCount = 0;
    cntUpCount = 0;
    doneCount  = 0;
  endtask

  // Leaves the bench at the falling edge inside the CLEAR cycle.
  task automatic startRun(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, ":clearPulse"}, 64'(clear), 64'd1);
    checkOutput({name, ":busyInClear"}, 64'(busy), 64'd1);
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] value, input bit ramp, input int gap,
                               input int first, input int count, input int dropAt);
    for (int i = first; i < first + count; i++) begin
      @(negedge clk);
      data_ready = 1'b1;
      sample = ramp ? i[DATA_W-1:0] : value;
      @(negedge clk);
      if (i == dropAt) begin
        sample = 16'd100;
        @(negedge clk);
        data_ready = 1'b0;
        repeat (gap - 3) @(negedge clk);
      end else begin
        data_ready = 1'b0;
        repeat (gap - 2) @(negedge clk);
      end
    end
  endtask

  // Final sample with exact latency checks: ADD at t+1, CHECK at t+2, done at t+3.
  task automatic finishRun(input logic [DATA_W-1:0] lastVal, input logic [ACC_W-1:0] expSum,
                           input bit expOverrun, input bit drInDone, input string name);
    @(negedge clk);
    data_ready = 1'b1;
    sample = lastVal;
    @(negedge clk);
    data_ready = 1'b0;
    checkOutput({name, ":cntUpInAdd"}, 64'(cnt_up), 64'd1);
    @(negedge clk);
    checkOutput({name, ":noEarlyDone"}, 64'(done), 64'd0);
    @(negedge clk);
    checkOutput({name, ":doneAtT3"}, 64'(done), 64'd1);
    checkOutput({name, ":sum"}, 64'(sum), 64'(expSum));
    checkOutput({name, ":busyInDone"}, 64'(busy), 64'd0);
    checkOutput({name, ":overrun"}, 64'(overrun), 64'(expOverrun));
    if (drInDone) data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    checkOutput({name, ":donePulseOneCycle"}, 64'(done), 64'd0);
    #1;
    checkOutput({name, ":clearCount"}, 64'(clearCount), 64'd1);
    checkOutput({name, ":cntUpCount"}, 64'(cntUpCount), 64'd1000);
    checkOutput({name, ":doneCount"}, 64'(doneCount), 64'd1);
    if (drInDone) begin
      @(negedge clk);
      #1;
      checkOutput({name, ":cntUpAfterDrInDone"}, 64'(cntUpCount), 64'd1000);
      checkOutput({name, ":overrunAfterDrInDone"}, 64'(overrun), 64'(expOverrun));
    end
  endtask

  initial begin
    vecs[0] = '{value: 16'd1,    ramp: 1'b0, gap: 4, expSum: 26'd1000};
    vecs[1] = '{value: 16'hFFFF, ramp: 1'b0, gap: 3, expSum: 26'd65535000};
    vecs[2] = '{value: 16'd2,    ramp: 1'b0, gap: 3, expSum: 26'd2000};
    vecs[3] = '{value: 16'd0,    ramp: 1'b1, gap: 5, expSum: 26'd499500};

    start = 1'b0;
    data_ready = 1'b0;
    sample = '0;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #2;
    checkOutput("reset:busy", 64'(busy), 64'd0);
    checkOutput("reset:done", 64'(done), 64'd0);
    checkOutput("reset:clear", 64'(clear), 64'd0);
    checkOutput("reset:cntUp", 64'(cnt_up), 64'd0);
    checkOutput("reset:overrun", 64'(overrun), 64'd0);
    checkOutput("reset:sum", 64'(sum), 64'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    lastSum = '0;

    for (int k = 0; k < 4; k++) begin
      string vname;
      vname = $sformatf("vec%0d", k);
      $display("[TB] run %s value=%0d ramp=%0b gap=%0d", vname, vecs[k].value, vecs[k].ramp, vecs[k].gap);
      resetCounts();
      startRun(vname);
      checkOutput({vname, ":sumHeld"}, 64'(sum), 64'(lastSum));
      applyStimulus(vecs[k].value, vecs[k].ramp, vecs[k].gap, 0, 999, -1);
      finishRun(vecs[k].ramp ? 16'd999 : vecs[k].value, vecs[k].expSum, 1'b0, 1'b0, vname);
      lastSum = vecs[k].expSum;
    end

    $display("[TB] overrun sequence");
    resetCounts();
    startRun("overrun");
    applyStimulus(16'd1, 1'b0, 4, 0, 999, 500);
    finishRun(16'd1, 26'd1000, 1'b1, 1'b0, "overrun");
    checkOutput("overrun:stickyInIdle", 64'(overrun), 64'd1);

    $display("[TB] ignored-input sequence");
    resetCounts();
    startRun("ignored");
    @(negedge clk);
    checkOutput("ignored:overrunClearedByStart", 64'(overrun), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(16'd5, 1'b0, 4, 0, 10, -1);
    @(negedge clk);
    data_ready = 1'b1;
    sample = 16'd5;
    @(negedge clk);
    data_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignored:busyAfterStartInAdd", 64'(busy), 64'd1);
    @(negedge clk);
    applyStimulus(16'd5, 1'b0, 4, 0, 988, -1);
    finishRun(16'd5, 26'd5000, 1'b0, 1'b1, "ignored");
    resetCounts();
    repeat (3) begin
      @(negedge clk);
      data_ready = 1'b1;
      sample = 16'd9;
      @(negedge clk);
      data_ready = 1'b0;
    end
    @(negedge clk);
    #1;
    checkOutput("idleDr:cntUpCount", 64'(cntUpCount), 64'd0);
    checkOutput("idleDr:clearCount", 64'(clearCount), 64'd0);
    checkOutput("idleDr:overrun", 64'(overrun), 64'd0);
    checkOutput("idleDr:busy", 64'(busy), 64'd0);

    $display("[TB] mid-run reset sequence");
    resetCounts();
    startRun("midReset");
    applyStimulus(16'd7, 1'b0, 4, 0, 499, -1);
    @(negedge clk);
    data_ready = 1'b1;
    sample = 16'd7;
    @(negedge clk);
    data_ready = 1'b0;
    checkOutput("midReset:cntUpBeforeReset", 64'(cnt_up), 64'd1);
    n_rst = 1'b0;
    #1;
    checkOutput("midReset:cntUp", 64'(cnt_up), 64'd0);
    checkOutput("midReset:busy", 64'(busy), 64'd0);
    checkOutput("midReset:sum", 64'(sum), 64'd0);
    checkOutput("midReset:done", 64'(done), 64'd0);
    checkOutput("midReset:overrun", 64'(overrun), 64'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    #1;
    checkOutput("midReset:noDone", 64'(doneCount), 64'd0);
    resetCounts();
    startRun("afterReset");
    applyStimulus(16'd3, 1'b0, 4, 0, 999, -1);
    finishRun(16'd3, 26'd3000, 1'b0, 1'b0, "afterReset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_accum_ctrl.md
Name: sample_accum_ctrl

Overview:
Sequencing controller for the 1000-sample counter block (`counter`: inputs cnt_up/clear, output one_k_samples). On a start request it clears the counter and an internal accumulator. It then adds each incoming sample and pulses cnt_up once per accepted sample. When one_k_samples returns it publishes the 1000-sample sum with a done pulse. It sits between the sample source and the downstream averaging/readout logic.

Parameters:
DATA_W, 16, sample width (unsigned).
ACC_W, 26, accumulator and sum width. Must be >= DATA_W+10 for overflow-free 1000-sample sums.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
start  input  1  request a new 1000-sample run. Level, sampled each cycle.
data_ready  input  1  one-cycle pulse: sample is valid this cycle.
sample  input  DATA_W  sample data, valid when data_ready=1.
one_k_samples  input  1  rollover flag from the counter block.
cnt_up  output  1  counter increment pulse.
clear  output  1  counter synchronous clear pulse.
busy  output  1  high while a run is in progress.
done  output  1  one-cycle pulse: sum is valid and updated.
overrun  output  1  sticky: a sample arrived while the previous one was still being processed.
sum  output  ACC_W  registered 1000-sample sum. Holds until the next done.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (n_rst). All state, including the counter, returns to reset values immediately on n_rst=0.
- Reset values: state=IDLE, cnt_up=0, clear=0, busy=0, done=0, overrun=0, sum=0, accumulator=0, sample holding register=0.
- States: IDLE, CLEAR, WAIT, ADD, CHECK, DONE. All control outputs are Moore (decoded from state). Only the sum/acc/hold registers load on transitions.
- IDLE: busy=0. start=1 -> CLEAR. data_ready is ignored (no cnt_up, no overrun).
- CLEAR (1 cycle): clear=1, busy=1, acc<=0, overrun<=0 -> WAIT.
- WAIT: busy=1. On data_ready=1, sample is latched into the holding register -> ADD.
- ADD (1 cycle): busy=1, cnt_up=1, acc<=acc+zero_ext(hold) -> CHECK.
- CHECK (1 cycle): busy=1. one_k_samples is sampled here; it is valid the cycle after the cnt_up pulse.
  - If one_k_samples=1: sum<=acc -> DONE.
  - Otherwise -> WAIT.
- DONE (1 cycle): done=1, busy=0 -> IDLE. sum is already valid in this cycle.
- Latency: data_ready of the 1000th sample in cycle t gives ADD at t+1, CHECK at t+2, done=1 and new sum at t+3.
- Sample rate limit: at most one accepted sample per 3 cycles.
- Overrun: data_ready=1 while in ADD, CHECK or CLEAR sets overrun=1. That sample is dropped (no cnt_up, no add) and the run continues. overrun clears only in CLEAR or on reset.
- data_ready=1 in DONE or IDLE: ignored, no overrun.
- Start handling: start is accepted only in IDLE. Any start in other states is ignored and does not restart the run. start held high through DONE begins a new run on the IDLE cycle after DONE.
- Arithmetic: unsigned, modulo 2^ACC_W, no saturation. With the default parameters 1000 x 65535 = 65,535,000 < 2^26, so there is no wrap.
- Counter ownership: cnt_up and clear are never asserted in the same cycle. cnt_up is asserted exactly once per accepted sample.
- Reset mid-run: immediate return to IDLE with all registers at reset values. The counter shares n_rst, so it is also reset to 0. No done is issued for the aborted run.

Test Plan:
1. Reset: assert n_rst=0 mid-simulation -> all outputs 0 and state IDLE, asynchronously and within the same cycle.
2. Nominal run: start=1 for 1 cycle, then 1000 data_ready pulses with sample=1, spaced 4 cycles apart -> exactly 1 clear pulse and 1000 cnt_up pulses. done=1 exactly 3 cycles after the last data_ready, with sum=1000 and overrun=0.
3. Max data: 1000 samples of 0xFFFF -> sum=65,535,000 (0x3E7FC18), no wrap. A following run of 1000 samples of 2 gives sum=2000, proving the accumulator was cleared.
4. Overrun: data_ready on two consecutive cycles during a run -> second sample dropped and overrun=1 stays set. The run needs 1000 accepted samples to finish. The next start clears overrun to 0.
5. Reset mid-run: pulse n_rst low after 500 samples -> busy=0, no done. A new start followed by 1000 samples of 3 gives sum=3000.
6. Ignored inputs: start pulsed during WAIT/ADD -> no extra clear pulse. data_ready pulses in IDLE -> no cnt_up and overrun stays 0.
